// File: rtl/regfile_wb_arbiter.sv
// Write-side master for the register file: merges the in-order pipeline writeback
// with buffered long-latency results and tracks outstanding LU destinations.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_valid,
    input  logic [4:0]                 pipe_rd,
    input  logic [XLEN-1:0]            pipe_data,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [4:0]                 lu_rd,
    input  logic [XLEN-1:0]            lu_data,
    input  logic                       iss_valid,
    input  logic [4:0]                 iss_rd,
    output logic                       stall_req,
    output logic                       RegWrite,
    output logic [4:0]                 rd,
    output logic [XLEN-1:0]            write_data,
    output logic [31:0]                pending_mask,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(STARVE_LIMIT+1);

    // Data lives in a RAM-style array read only into the output register; the small
    // tag array is read combinationally so the scoreboard clear can coincide with the write.
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [4:0]      tag_mem  [DEPTH];

    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [SW-1:0]   starve_reg;
    logic [SW-1:0]   starve_next;
    logic            reg_write_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] write_data_reg;
    logic [31:0]     pending_reg;

    logic            pipe_req;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [4:0]      head_rd;
    logic [31:0]     set_vec;
    logic [31:0]     clr_vec;

    assign pipe_req   = pipe_valid && (pipe_rd != 5'd0);
    assign fifo_empty = (count_reg == '0);
    assign lu_ready   = rst && (count_reg < CW'(DEPTH));
    assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);
    assign pop        = !pipe_req && !fifo_empty;
    assign head_rd    = tag_mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Counts consecutive cycles the queued head loses the port to the pipeline.
    always_comb begin
        starve_next = '0;
        if (!fifo_empty && pipe_req) begin
            if (starve_reg == SW'(STARVE_LIMIT)) begin
                starve_next = starve_reg;
            end else begin
                starve_next = starve_reg + SW'(1);
            end
        end
    end

    genvar gi;
    assign set_vec[0] = 1'b0;
    assign clr_vec[0] = 1'b0;
    for (gi = 1; gi < 32; gi++) begin : g_sb
        assign set_vec[gi] = iss_valid && (iss_rd == 5'(gi));
        assign clr_vec[gi] = pop && (head_rd == 5'(gi));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= lu_data;
            tag_mem[wr_ptr_reg]  <= lu_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            starve_reg     <= '0;
            reg_write_reg  <= 1'b0;
            rd_reg         <= 5'd0;
            write_data_reg <= '0;
            pending_reg    <= '0;
        end else begin
            count_reg   <= count_next;
            starve_reg  <= starve_next;
            // A new issue to the same register outranks the retiring write.
            pending_reg <= (pending_reg & ~clr_vec) | set_vec;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pipe_req) begin
                reg_write_reg  <= 1'b1;
                rd_reg         <= pipe_rd;
                write_data_reg <= pipe_data;
            end else if (pop) begin
                reg_write_reg  <= 1'b1;
                rd_reg         <= head_rd;
                write_data_reg <= data_mem[rd_ptr_reg];
                rd_ptr_reg     <= rd_ptr_reg + AW'(1);
            end else begin
                reg_write_reg  <= 1'b0;
            end
        end
    end

    assign stall_req    = (starve_reg == SW'(STARVE_LIMIT));
    assign RegWrite     = reg_write_reg;
    assign rd           = rd_reg;
    assign write_data   = write_data_reg;
    assign pending_mask = pending_reg;
    assign fifo_count   = count_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        stall_req;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .stall_req(stall_req),
        .RegWrite(RegWrite), .rd(rd), .write_data(write_data),
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: the LU buffer is a plain queue, the scoreboard a bit array.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pend = '0;
    int          m_starve = 0;

    task automatic tick();
        bit   preq;
        bit   pop;
        bit   acc;
        ent_t e;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_we = 1'b0; m_rd = '0; m_data = '0; m_pend = '0; m_starve = 0;
        end else begin
            preq = pipe_valid && (pipe_rd != 0);
            pop  = !preq && (mq.size() != 0);
            acc  = lu_valid && (mq.size() < DEPTH);
            if (mq.size() != 0 && preq) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else m_starve = 0;
            if (preq) begin
                m_we = 1'b1; m_rd = pipe_rd; m_data = pipe_data;
            end else if (pop) begin
                e = mq.pop_front();
                m_we = 1'b1; m_rd = e.rd; m_data = e.data;
                m_pend[e.rd] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            if (acc && lu_rd != 0) begin
                e.rd = lu_rd; e.data = lu_data;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h55;
        lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h66;
        iss_valid = 1'b1; iss_rd = 5'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (RegWrite !== 1'b0 || pending_mask !== 32'd0 || lu_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_hold cyc%0d: RegWrite=%b pending=%h lu_ready=%b, required 0/0/0",
                         i, RegWrite, pending_mask, lu_ready);
            end
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if (lu_ready !== 1'b1 || fifo_count !== 3'd0 || stall_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: lu_ready=%b fifo_count=%0d stall=%b, required 1/0/0",
                     lu_ready, fifo_count, stall_req);
        end
        $display("txn reset released");
        tick();
    endtask

    task automatic test_pipe();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        tick();
        n_checks++;
        if (RegWrite !== 1'b1 || rd !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL pipe_write: we=%b rd=%0d data=%h, required 1/5/deadbeef", RegWrite, rd, write_data);
        end
        $display("txn pipe write rd=%0d data=%h", rd, write_data);
        pipe_rd = 5'd0; pipe_data = 32'h11111111;
        tick();
        n_checks++;
        if (RegWrite !== 1'b0 || rd !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL pipe_rd0: we=%b rd=%0d data=%h, required 0/5/deadbeef (hold)", RegWrite, rd, write_data);
        end
        idle_inputs();
    endtask

    task automatic test_lu_latency();
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        n_checks++;
        if (pending_mask[7] !== 1'b1) begin
            n_errors++;
            $display("FAIL issue_set: pending[7]=%b, required 1", pending_mask[7]);
        end
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
        #1;
        n_checks++;
        if (lu_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_ready_empty: lu_ready=%b, required 1", lu_ready);
        end
        tick();
        lu_valid = 1'b0;
        n_checks++;
        if (RegWrite !== 1'b0 || pending_mask[7] !== 1'b1 || fifo_count !== 3'd1) begin
            n_errors++;
            $display("FAIL lu_no_bypass: we=%b pending[7]=%b count=%0d, required 0/1/1",
                     RegWrite, pending_mask[7], fifo_count);
        end
        tick();
        n_checks++;
        if (RegWrite !== 1'b1 || rd !== 5'd7 || write_data !== 32'h1234 || pending_mask[7] !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_write: we=%b rd=%0d data=%h pending[7]=%b, required 1/7/1234/0",
                     RegWrite, rd, write_data, pending_mask[7]);
        end
        $display("txn lu write rd=%0d data=%h", rd, write_data);
        tick();
    endtask

    task automatic test_full();
        logic [4:0] exp_rd;
        pipe_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pipe_rd = 5'(20 + i); pipe_data = 32'(i);
            lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_data = 32'hA0 + 32'(i);
            tick();
        end
        lu_rd = 5'd14; lu_data = 32'hA4;
        #1;
        n_checks++;
        if (fifo_count !== 3'd4 || lu_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL fifo_full: count=%0d lu_ready=%b, required 4/0", fifo_count, lu_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (fifo_count !== 3'd4 || lu_ready !== 1'b0 || RegWrite !== 1'b1 || rd !== 5'd23) begin
                n_errors++;
                $display("FAIL full_hold: count=%0d lu_ready=%b we=%b rd=%0d, required 4/0/1/23",
                         fifo_count, lu_ready, RegWrite, rd);
            end
        end
        pipe_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) lu_valid = 1'b0;
            exp_rd = 5'(10 + i);
            n_checks++;
            if (RegWrite !== 1'b1 || rd !== exp_rd || write_data !== 32'hA0 + 32'(i)) begin
                n_errors++;
                $display("FAIL fifo_order%0d: we=%b rd=%0d data=%h, required 1/%0d/%h",
                         i, RegWrite, rd, write_data, exp_rd, 32'hA0 + 32'(i));
            end
            $display("txn drain rd=%0d data=%h", rd, write_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starve();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h77;
        lu_valid = 1'b1; lu_rd = 5'd15; lu_data = 32'hF15;
        tick();
        lu_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            n_checks++;
            if (stall_req !== (k >= 9)) begin
                n_errors++;
                $display("FAIL starve_cyc%0d: stall_req=%b, required %0d", k, stall_req, (k >= 9));
            end
            if (k == 10) pipe_valid = 1'b0;
            tick();
        end
        n_checks++;
        if (stall_req !== 1'b0 || RegWrite !== 1'b1 || rd !== 5'd15 || write_data !== 32'hF15) begin
            n_errors++;
            $display("FAIL starve_pop: stall=%b we=%b rd=%0d data=%h, required 0/1/15/f15",
                     stall_req, RegWrite, rd, write_data);
        end
        $display("txn starved write rd=%0d", rd);
        idle_inputs();
        tick();
    endtask

    task automatic test_corner();
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        tick();
        lu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        n_checks++;
        if (RegWrite !== 1'b1 || rd !== 5'd9 || pending_mask[9] !== 1'b1) begin
            n_errors++;
            $display("FAIL set_clear_same: we=%b rd=%0d pending[9]=%b, required 1/9/1", RegWrite, rd, pending_mask[9]);
        end
        iss_valid = 1'b1; iss_rd = 5'd0;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hBAD;
        #1;
        n_checks++;
        if (lu_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_rd0_ready: lu_ready=%b, required 1", lu_ready);
        end
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (RegWrite !== 1'b0 || fifo_count !== 3'd0 || pending_mask[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL lu_rd0_drop%0d: we=%b count=%0d pending[0]=%b, required 0/0/0",
                         i, RegWrite, fifo_count, pending_mask[0]);
            end
            tick();
        end
        pipe_valid = 1'b1; pipe_rd = 5'd2;
        lu_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lu_rd = 5'(16 + i); lu_data = 32'h160 + 32'(i);
            tick();
        end
        pipe_valid = 1'b0;
        lu_rd = 5'd18; lu_data = 32'h162;
        tick();
        lu_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd2 || RegWrite !== 1'b1 || rd !== 5'd16 || write_data !== 32'h160) begin
            n_errors++;
            $display("FAIL push_pop_count: count=%0d we=%b rd=%0d data=%h, required 2/1/16/160",
                     fifo_count, RegWrite, rd, write_data);
        end
        $display("txn push+pop rd=%0d count=%0d", rd, fifo_count);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 79) != 0);
            pipe_valid = (m_starve == LIMIT) ? 1'b0 : ($urandom_range(0, 99) < 60);
            pipe_rd    = 5'($urandom_range(0, 31));
            pipe_data  = $urandom();
            lu_valid   = 1'($urandom_range(0, 1));
            lu_rd      = 5'($urandom_range(0, 31));
            lu_data    = $urandom();
            iss_valid  = ($urandom_range(0, 3) == 0);
            iss_rd     = 5'($urandom_range(0, 31));
            #1;
            n_checks++;
            if (lu_ready !== (rst && mq.size() < DEPTH)) begin
                n_errors++;
                $display("FAIL rand_ready c%0d: lu_ready=%b, required %0d", c, lu_ready, (rst && mq.size() < DEPTH));
            end
            tick();
            n_checks++;
            if (RegWrite !== m_we || rd !== m_rd || write_data !== m_data || pending_mask !== m_pend ||
                fifo_count !== 3'(mq.size()) || stall_req !== (m_starve == LIMIT)) begin
                n_errors++;
                $display("FAIL rand_state c%0d: we=%b rd=%0d data=%h pend=%h cnt=%0d stall=%b, required %b/%0d/%h/%h/%0d/%0d",
                         c, RegWrite, rd, write_data, pending_mask, fifo_count, stall_req,
                         m_we, m_rd, m_data, m_pend, mq.size(), (m_starve == LIMIT));
            end
            if (m_we) $display("txn rand c%0d write rd=%0d data=%h", c, m_rd, m_data);
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_lu_latency();
        test_full();
        test_starve();
        test_corner();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
